// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing with mem timeout and illegal-op trap.
// Optional PERF_CNT_EN adds cycle_cnt_o / instr_cnt_o performance counters.
module mips_multicycle_ctrl #(
    parameter int ALU_OP_W    = 4,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op_i,
    input  logic [5:0]          funct_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          alu_srca,
    output logic [1:0]          alu_srcb,
    output logic                ext_op,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic [3:0]          state_o,
    output logic                trap_o,
    output logic [1:0]          trap_cause_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]         cycle_cnt_o,
    output logic [31:0]         instr_cnt_o
`endif
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
        S_WB_R = 4'd8, S_WB_I = 4'd9, S_WB_MEM = 4'd10, S_BRANCH = 4'd11,
        S_JUMP = 4'd12, S_JR = 4'd13, S_TRAP = 4'd14
    } state_e;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
        OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
        OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] F_JR = 6'b001000;

    // Returns {legal, alu_op} for R-type arithmetic/logic/shift functs.
    function automatic logic [4:0] r_dec(input logic [5:0] f);
        case (f)
            6'b000000: r_dec = {1'b1, 4'd7};
            6'b000010: r_dec = {1'b1, 4'd8};
            6'b000011: r_dec = {1'b1, 4'd9};
            6'b100000: r_dec = {1'b1, 4'd0};
            6'b100010: r_dec = {1'b1, 4'd1};
            6'b100100: r_dec = {1'b1, 4'd2};
            6'b100101: r_dec = {1'b1, 4'd3};
            6'b100110: r_dec = {1'b1, 4'd4};
            6'b101010: r_dec = {1'b1, 4'd5};
            6'b101011: r_dec = {1'b1, 4'd6};
            default:   r_dec = {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic [3:0] i_dec(input logic [5:0] o);
        case (o)
            OP_SLTI: i_dec = 4'd5;
            OP_ANDI: i_dec = 4'd2;
            OP_ORI:  i_dec = 4'd3;
            OP_XORI: i_dec = 4'd4;
            default: i_dec = 4'd0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       cause_q, cause_d;
    logic             trap_q;
    logic [4:0]       rd;
    logic             mem_wait;

    assign rd       = r_dec(funct_i);
    assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        tmo_d   = '0;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_R: begin
                        if (funct_i == F_JR) state_d = S_JR;
                        else if (rd[4])      state_d = S_EXEC_R;
                        else begin
                            state_d = S_TRAP;
                            cause_d = 2'd1;
                        end
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'd1;
                    end
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready_i) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
        // A ready on the final allowed wait cycle still completes the transfer.
        if (mem_wait && !mem_ready_i) begin
            if (tmo_q == TMO_W'(MEM_TIMEOUT)) begin
                state_d = S_TRAP;
                cause_d = 2'd2;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cause_q <= 2'd0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cause_q <= cause_d;
            trap_q  <= trap_q || (state_d == S_TRAP);
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP)
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (state_d == S_FETCH && state_q inside {S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR,
                                                      S_BRANCH, S_JUMP, S_JR})
                instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end
    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`endif

    logic [3:0] alu_op_c;

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_op_c   = 4'd0;
        alu_srca   = 2'd0;
        alu_srcb   = 2'd0;
        ext_op     = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                alu_srcb = 2'd1;
                ir_write = mem_ready_i;
                pc_write = mem_ready_i;
            end
            S_DECODE: begin
                alu_srcb = 2'd3;
                ext_op   = 1'b1;
            end
            S_EXEC_R: begin
                alu_op_c = rd[3:0];
                alu_srca = (funct_i[5:2] == 4'b0000) ? 2'd2 : 2'd1;
            end
            S_EXEC_I: begin
                alu_srca = 2'd1;
                alu_srcb = 2'd2;
                alu_op_c = i_dec(op_i);
                ext_op   = (op_i == OP_ADDI) || (op_i == OP_SLTI);
            end
            S_MEM_ADDR: begin
                alu_srca = 2'd1;
                alu_srcb = 2'd2;
                ext_op   = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_WB_I:   reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_srca = 2'd1;
                alu_op_c = 4'd1;
                pc_src   = 2'd1;
                pc_write = (op_i == OP_BNE) ? ~zero_i : zero_i;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'd3;
            end
            default: ;
        endcase
    end

    assign alu_op       = ALU_OP_W'(alu_op_c);
    assign state_o      = state_q;
    assign trap_o       = trap_q;
    assign trap_cause_o = cause_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class, timeout boundary and trap/reset.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_i, funct_i;
    logic       zero_i, mem_ready_i;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, ext_op, reg_dst, reg_write, mem_to_reg;
    logic [1:0] pc_src, alu_srca, alu_srcb, trap_cause_o;
    logic [3:0] alu_op, state_o;
    logic       trap_o;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif
    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .ext_op(ext_op), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state_o(state_o),
        .trap_o(trap_o), .trap_cause_o(trap_cause_o)
`ifdef PERF_CNT_EN
        , .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {27'd0, mem_req, mem_we, ir_write, pc_write, reg_write}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; op_i = 6'd0; funct_i = 6'd0; zero_i = 1'b0; mem_ready_i = 1'b0;
        tick(); tick();
        chk("rst_state", state_o, 0);
        chk("rst_trap", trap_o, 0);
        chk("rst_cause", trap_cause_o, 0);
        chk_quiet("rst_strobes");
`ifdef PERF_CNT_EN
        chk("rst_cyc", cycle_cnt_o, 0);
        chk("rst_ins", instr_cnt_o, 0);
`endif
        // ADD
        rst_n = 1'b1; op_i = 6'b000000; funct_i = 6'b100000; mem_ready_i = 1'b1;
        #1 chk("idle_strobes_zero", {27'd0, mem_req, mem_we, ir_write, pc_write, reg_write}, 0);
        tick();
        chk("add_fetch_state", state_o, 1);
        chk("add_fetch_strb", {mem_req, i_or_d, ir_write, pc_write, pc_src, alu_srca, alu_srcb, reg_write},
            {1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0});
        tick();
        chk("add_decode", {state_o, alu_srca, alu_srcb, ext_op, mem_req}, {4'd2, 2'd0, 2'd3, 1'b1, 1'b0});
        tick();
        chk("add_exec", {state_o, alu_op, alu_srca, alu_srcb, reg_write}, {4'd3, 4'd0, 2'd1, 2'd0, 1'b0});
        tick();
        chk("add_wb", {state_o, reg_write, reg_dst, mem_to_reg}, {4'd8, 1'b1, 1'b1, 1'b0});
        tick();
        chk("add_back_fetch", state_o, 1);
`ifdef PERF_CNT_EN
        chk("add_cyc", cycle_cnt_o, 4);
        chk("add_ins", instr_cnt_o, 1);
`endif
        // LW with 3 wait cycles in MEM_RD
        op_i = 6'b100011;
        tick();
        chk("lw_decode", state_o, 2);
        tick();
        chk("lw_addr", {state_o, alu_srca, alu_srcb, ext_op, alu_op}, {4'd5, 2'd1, 2'd2, 1'b1, 4'd0});
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_memrd_wait", {state_o, mem_req, i_or_d, reg_write}, {4'd6, 1'b1, 1'b1, 1'b0});
        end
        tick();
        mem_ready_i = 1'b1;
        chk("lw_memrd_last", {state_o, mem_req, i_or_d}, {4'd6, 1'b1, 1'b1});
        tick();
        chk("lw_wbmem", {state_o, mem_to_reg, reg_write, reg_dst}, {4'd10, 1'b1, 1'b1, 1'b0});
        tick();
        chk("lw_back_fetch", state_o, 1);
        // BEQ / BNE with zero_i=0
        op_i = 6'b000100; zero_i = 1'b0;
        tick(); tick();
        chk("beq_branch", {state_o, pc_write, pc_src, alu_op, alu_srca, alu_srcb},
            {4'd11, 1'b0, 2'd1, 4'd1, 2'd1, 2'd0});
        zero_i = 1'b1;
        #1 chk("beq_taken", pc_write, 1);
        zero_i = 1'b0;
        tick();
        chk("beq_back_fetch", state_o, 1);
        op_i = 6'b000101;
        tick(); tick();
        chk("bne_branch", {state_o, pc_write, pc_src}, {4'd11, 1'b1, 2'd1});
        zero_i = 1'b1;
        #1 chk("bne_not_taken", pc_write, 0);
        zero_i = 1'b0;
        tick();
        chk("bne_back_fetch", state_o, 1);
        // SLL
        op_i = 6'b000000; funct_i = 6'b000000;
        tick(); tick();
        chk("sll_exec", {state_o, alu_srca, alu_srcb, alu_op}, {4'd3, 2'd2, 2'd0, 4'd7});
        tick(); tick();
        // SRA
        funct_i = 6'b000011;
        tick(); tick();
        chk("sra_exec", {state_o, alu_srca, alu_op}, {4'd3, 2'd2, 4'd9});
        tick(); tick();
        // ORI
        op_i = 6'b001101;
        tick(); tick();
        chk("ori_exec", {state_o, ext_op, alu_op, alu_srca, alu_srcb}, {4'd4, 1'b0, 4'd3, 2'd1, 2'd2});
        tick();
        chk("ori_wb", {state_o, reg_write, reg_dst, mem_to_reg}, {4'd9, 1'b1, 1'b0, 1'b0});
        tick();
        // SLTI sign-extends
        op_i = 6'b001010;
        tick(); tick();
        chk("slti_exec", {state_o, ext_op, alu_op}, {4'd4, 1'b1, 4'd5});
        tick(); tick();
        // SW
        op_i = 6'b101011;
        tick(); tick(); tick();
        chk("sw_memwr", {state_o, mem_req, mem_we, i_or_d}, {4'd7, 1'b1, 1'b1, 1'b1});
        tick();
        chk("sw_back_fetch", state_o, 1);
        // J and JR
        op_i = 6'b000010;
        tick(); tick();
        chk("j_jump", {state_o, pc_write, pc_src}, {4'd12, 1'b1, 2'd2});
        tick();
        op_i = 6'b000000; funct_i = 6'b001000;
        tick(); tick();
        chk("jr_jr", {state_o, pc_write, pc_src}, {4'd13, 1'b1, 2'd3});
        tick();
        chk("jr_back_fetch", state_o, 1);
        // Illegal opcode
        op_i = 6'b111111;
        tick(); tick();
        chk("ill_trap", {state_o, trap_o, trap_cause_o}, {4'd14, 1'b1, 2'd1});
        chk_quiet("ill_trap_strobes");
        for (int i = 0; i < 10; i++) tick();
        chk("ill_trap_held", {state_o, trap_o, trap_cause_o}, {4'd14, 1'b1, 2'd1});
        rst_n = 1'b0;
        tick();
        chk("ill_reset", {state_o, trap_o, trap_cause_o}, {4'd0, 1'b0, 2'd0});
        // Timeout boundary: ready on the 16th wait cycle still completes
        rst_n = 1'b1; op_i = 6'b000000; funct_i = 6'b100000; mem_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_fetch_15", state_o, 1);
        tick();
        mem_ready_i = 1'b1;
        #1 chk("tmo_last_ir_write", ir_write, 1);
        tick();
        chk("tmo_boundary_decode", {state_o, trap_o}, {4'd2, 1'b0});
        // Reset mid-instruction
        rst_n = 1'b0;
        tick();
        chk("mid_reset_state", state_o, 0);
        chk_quiet("mid_reset_strobes");
        // Timeout trap
        rst_n = 1'b1; mem_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("tmo_fetch_wait", state_o, 1);
        end
        tick();
        chk("tmo_trap", {state_o, trap_o, trap_cause_o}, {4'd14, 1'b1, 2'd2});
`ifdef PERF_CNT_EN
        chk("tmo_cyc", cycle_cnt_o, 16);
        chk("tmo_ins", instr_cnt_o, 0);
`endif
        mem_ready_i = 1'b1;
        tick(); tick(); tick();
        chk("tmo_trap_held", {state_o, trap_cause_o}, {4'd14, 2'd2});
`ifdef PERF_CNT_EN
        chk("tmo_cyc_frozen", cycle_cnt_o, 16);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
